// File: rtl/im_loader.sv
// im_loader: streams a program from a loader port into instruction memory while
// holding the core, then releases the core once the last word has been written.
//
// Optional feature: define IM_LOADER_CHECKSUM_EN to add a CHECK state. In that
// build the loader sends one extra word after the last program word. That word
// must equal the modulo-2^32 sum of the program words, or the load fails.
//
// Ports:
//   clk, rst_n        clock; asynchronous active-low reset
//   start             one-cycle request to begin a (re)load
//   ld_valid/ld_data/ld_last, ld_ready   loader word handshake
//   im_we/im_waddr/im_wdata              instruction-memory write port (1-cycle latency)
//   cpu_hold          keeps the core stalled while high
//   done / err        load finished and core running / load failed
//   count             words written in the current or last load
module im_loader #(
  parameter int DEPTH = 32,
  parameter int AW    = 5
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic          ld_valid,
  input  logic [31:0]   ld_data,
  input  logic          ld_last,
  output logic          ld_ready,
  output logic          im_we,
  output logic [AW-1:0] im_waddr,
  output logic [31:0]   im_wdata,
  output logic          cpu_hold,
  output logic          done,
  output logic          err,
  output logic [AW:0]   count
);

  localparam logic [2:0] StIdle  = 3'd0;
  localparam logic [2:0] StLoad  = 3'd1;
  localparam logic [2:0] StRun   = 3'd2;
  localparam logic [2:0] StError = 3'd3;
`ifdef IM_LOADER_CHECKSUM_EN
  localparam logic [2:0] StCheck = 3'd4;
`endif

  localparam logic [AW:0] LastIdx = (AW+1)'(DEPTH - 1);

  logic [2:0]    state_q, state_d;
  logic [AW:0]   count_q, count_d;
  logic          we_q, we_d;
  logic [AW-1:0] waddr_q, waddr_d;
  logic [31:0]   wdata_q, wdata_d;
  logic          hs;
`ifdef IM_LOADER_CHECKSUM_EN
  logic [31:0]   sum_q, sum_d;
`endif

`ifdef IM_LOADER_CHECKSUM_EN
  assign ld_ready = (state_q == StLoad) || (state_q == StCheck);
`else
  assign ld_ready = (state_q == StLoad);
`endif
  assign hs = ld_valid & ld_ready;

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    we_d    = 1'b0;
    waddr_d = waddr_q;
    wdata_d = wdata_q;
`ifdef IM_LOADER_CHECKSUM_EN
    sum_d   = sum_q;
`endif
    case (state_q)
      StIdle, StRun, StError: begin
        if (start) begin
          state_d = StLoad;
          count_d = '0;
`ifdef IM_LOADER_CHECKSUM_EN
          sum_d   = '0;
`endif
        end
      end
      StLoad: begin
        if (hs) begin
          we_d    = 1'b1;
          waddr_d = count_q[AW-1:0];
          wdata_d = ld_data;
          count_d = count_q + 1'b1;
`ifdef IM_LOADER_CHECKSUM_EN
          sum_d   = sum_q + ld_data;
          if (ld_last) state_d = StCheck;
`else
          if (ld_last) state_d = StRun;
`endif
          // The final slot was just filled and more words are coming: stop
          // instead of wrapping back onto address 0.
          else if (count_q == LastIdx) state_d = StError;
        end
      end
`ifdef IM_LOADER_CHECKSUM_EN
      StCheck: begin
        // Checksum word is compared only, never written to memory.
        if (hs) state_d = (ld_data == sum_q) ? StRun : StError;
      end
`endif
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      count_q <= '0;
      we_q    <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
`ifdef IM_LOADER_CHECKSUM_EN
      sum_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      we_q    <= we_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
`ifdef IM_LOADER_CHECKSUM_EN
      sum_q   <= sum_d;
`endif
    end
  end

  assign im_we    = we_q;
  assign im_waddr = waddr_q;
  assign im_wdata = wdata_q;
  assign count    = count_q;
  // RUN is entered in the same cycle as the final write; keep the core held
  // until that write has retired.
  assign cpu_hold = (state_q != StRun) | we_q;
  assign done     = (state_q == StRun) & ~we_q;
  assign err      = (state_q == StError);

endmodule

// File: tb/tb_im_loader.sv
// Directed self-checking bench for im_loader (default build, and checksum build
// when IM_LOADER_CHECKSUM_EN is defined).
module tb_im_loader;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        ld_valid;
  logic [31:0] ld_data;
  logic        ld_last;
  logic        ld_ready;
  logic        im_we;
  logic [4:0]  im_waddr;
  logic [31:0] im_wdata;
  logic        cpu_hold;
  logic        done;
  logic        err;
  logic [5:0]  count;

  int errors = 0;
  int checks = 0;

  im_loader #(.DEPTH(32), .AW(5)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .ld_valid (ld_valid),
    .ld_data  (ld_data),
    .ld_last  (ld_last),
    .ld_ready (ld_ready),
    .im_we    (im_we),
    .im_waddr (im_waddr),
    .im_wdata (im_wdata),
    .cpu_hold (cpu_hold),
    .done     (done),
    .err      (err),
    .count    (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // After the last program word: in the checksum build, send the sum word.
  task automatic close_load(input logic [31:0] sum);
`ifdef IM_LOADER_CHECKSUM_EN
    ld_valid = 1'b1;
    ld_data  = sum;
    ld_last  = 1'b0;
    tick();
    ld_valid = 1'b0;
    chk("cksum_no_write", {31'd0, im_we}, 32'd0);
`else
    ld_data = sum;
`endif
  endtask

  initial begin
    rst_n    = 1'b0;
    start    = 1'b0;
    ld_valid = 1'b0;
    ld_data  = '0;
    ld_last  = 1'b0;
    #1;
    chk("rst_hold",  {31'd0, cpu_hold}, 32'd1);
    chk("rst_we",    {31'd0, im_we},    32'd0);
    chk("rst_waddr", {27'd0, im_waddr}, 32'd0);
    chk("rst_wdata", im_wdata,          32'd0);
    chk("rst_ready", {31'd0, ld_ready}, 32'd0);
    chk("rst_done",  {31'd0, done},     32'd0);
    chk("rst_err",   {31'd0, err},      32'd0);
    chk("rst_count", {26'd0, count},    32'd0);
    #20 rst_n = 1'b1;
    tick();

    // Basic three-word program.
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("load_ready", {31'd0, ld_ready}, 32'd1);
    chk("load_hold",  {31'd0, cpu_hold}, 32'd1);
    ld_valid = 1'b1; ld_data = 32'h0030_0413; ld_last = 1'b0;
    tick();
    chk("w0_we",    {31'd0, im_we},    32'd1);
    chk("w0_addr",  {27'd0, im_waddr}, 32'd0);
    chk("w0_data",  im_wdata,          32'h0030_0413);
    chk("w0_count", {26'd0, count},    32'd1);
    ld_data = 32'h0010_0493;
    tick();
    chk("w1_we",   {31'd0, im_we},    32'd1);
    chk("w1_addr", {27'd0, im_waddr}, 32'd1);
    chk("w1_data", im_wdata,          32'h0010_0493);
    ld_data = 32'h0100_0913; ld_last = 1'b1;
    tick();
    ld_valid = 1'b0; ld_last = 1'b0;
    chk("w2_we",    {31'd0, im_we},    32'd1);
    chk("w2_addr",  {27'd0, im_waddr}, 32'd2);
    chk("w2_data",  im_wdata,          32'h0100_0913);
    chk("w2_count", {26'd0, count},    32'd3);
    chk("w2_hold",  {31'd0, cpu_hold}, 32'd1);
    close_load(32'h0140_11B9);
    tick();
    chk("run_we",    {31'd0, im_we},    32'd0);
    chk("run_done",  {31'd0, done},     32'd1);
    chk("run_hold",  {31'd0, cpu_hold}, 32'd0);
    chk("run_ready", {31'd0, ld_ready}, 32'd0);
    chk("run_count", {26'd0, count},    32'd3);

    // Loader traffic while running is ignored.
    ld_valid = 1'b1; ld_data = 32'hDEAD_BEEF;
    tick();
    ld_valid = 1'b0;
    chk("run_ign_we",    {31'd0, im_we}, 32'd0);
    chk("run_ign_count", {26'd0, count}, 32'd3);

    // Restart from RUN, then a gappy valid stream.
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("rst_run_hold",  {31'd0, cpu_hold}, 32'd1);
    chk("rst_run_done",  {31'd0, done},     32'd0);
    chk("rst_run_count", {26'd0, count},    32'd0);
    ld_valid = 1'b1; ld_data = 32'h1111_1111;
    tick();
    chk("g0_we",   {31'd0, im_we},    32'd1);
    chk("g0_addr", {27'd0, im_waddr}, 32'd0);
    ld_valid = 1'b0;
    tick();
    chk("gap0_we", {31'd0, im_we}, 32'd0);
    chk("gap0_count", {26'd0, count}, 32'd1);
    ld_valid = 1'b1; ld_data = 32'h2222_2222; ld_last = 1'b1;
    tick();
    chk("g1_we",   {31'd0, im_we},    32'd1);
    chk("g1_addr", {27'd0, im_waddr}, 32'd1);
    chk("g1_data", im_wdata,          32'h2222_2222);
    ld_valid = 1'b0; ld_last = 1'b0;
    tick();
    chk("gap1_we", {31'd0, im_we}, 32'd0);
    close_load(32'h3333_3333);
    tick();
    chk("g_done", {31'd0, done}, 32'd1);

    // Overflow: 32 words, never marked last.
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 32; i++) begin
      ld_valid = 1'b1; ld_data = 32'hA000_0000 + i; ld_last = 1'b0;
      tick();
      chk("ovf_we",   {31'd0, im_we},    32'd1);
      chk("ovf_addr", {27'd0, im_waddr}, i);
      chk("ovf_data", im_wdata,          32'hA000_0000 + i);
    end
    chk("ovf_err",  {31'd0, err},      32'd1);
    chk("ovf_hold", {31'd0, cpu_hold}, 32'd1);
    tick();
    chk("ovf_nowrap_we", {31'd0, im_we},    32'd0);
    chk("ovf_count",     {26'd0, count},    32'd32);
    chk("ovf_ready",     {31'd0, ld_ready}, 32'd0);
    chk("ovf_done",      {31'd0, done},     32'd0);
    tick();
    chk("ovf_nowrap2_we", {31'd0, im_we}, 32'd0);
    ld_valid = 1'b0;

    // Restart from ERROR, then reset after two of five words.
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("err_clr",   {31'd0, err},   32'd0);
    chk("err_count", {26'd0, count}, 32'd0);
    ld_valid = 1'b1; ld_data = 32'h5555_0000;
    tick();
    ld_data = 32'h5555_0001;
    tick();
    chk("pre_rst_we", {31'd0, im_we}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_we",    {31'd0, im_we},    32'd0);
    chk("mid_rst_count", {26'd0, count},    32'd0);
    chk("mid_rst_done",  {31'd0, done},     32'd0);
    chk("mid_rst_hold",  {31'd0, cpu_hold}, 32'd1);
    chk("mid_rst_ready", {31'd0, ld_ready}, 32'd0);
    #2 rst_n = 1'b1;
    tick();
    chk("idle_ign_we",    {31'd0, im_we},    32'd0);
    chk("idle_ign_ready", {31'd0, ld_ready}, 32'd0);
    ld_valid = 1'b0;

`ifdef IM_LOADER_CHECKSUM_EN
    // Good and bad checksum.
    start = 1'b1;
    tick();
    start = 1'b0;
    ld_valid = 1'b1; ld_data = 32'h1;
    tick();
    ld_data = 32'h2; ld_last = 1'b1;
    tick();
    ld_last = 1'b0; ld_data = 32'h3;
    tick();
    ld_valid = 1'b0;
    chk("ck_ok_we",   {31'd0, im_we}, 32'd0);
    chk("ck_ok_done", {31'd0, done},  32'd1);
    start = 1'b1;
    tick();
    start = 1'b0;
    ld_valid = 1'b1; ld_data = 32'h1;
    tick();
    ld_data = 32'h2; ld_last = 1'b1;
    tick();
    ld_last = 1'b0; ld_data = 32'h4;
    tick();
    ld_valid = 1'b0;
    chk("ck_bad_we",   {31'd0, im_we}, 32'd0);
    chk("ck_bad_err",  {31'd0, err},   32'd1);
    chk("ck_bad_done", {31'd0, done},  32'd0);
    tick();
    chk("ck_bad_we2", {31'd0, im_we}, 32'd0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
